// File: rtl/mem_arb_pkg.sv
// =============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared types and constants for the data memory arbiter.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_CPU  = 2'd1,
        RSP_DBG  = 2'd2
    } rsp_own_t;

    localparam int WAIT_CNT_W   = 4;
    localparam int DEF_MAX_WAIT = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
// =============================================================================
// Module  : mem_arb_starve_ctr
// Brief   : Saturating count of consecutive denied cycles; flags a forced win.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_arb_starve_ctr
    import mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  gnt,
    input  logic [WAIT_CNT_W-1:0] limit,
    output logic                  force_win
);

    logic [WAIT_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!req || gnt) begin
            r_cnt <= '0;
        end else if (r_cnt < limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign force_win = req && (r_cnt == limit);

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// =============================================================================
// Module  : data_mem_arbiter
// Brief   : CPU/debug arbiter for the single-port data memory, with read
//           response routing and CPU stall. Optional lock: MEM_ARB_LOCK_EN.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef MEM_ARB_LOCK_EN
    input  logic              dbg_lock,
`endif
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_enbl,
    output logic              mem_write_enbl,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [WAIT_CNT_W-1:0] c_max_wait = MAX_WAIT[WAIT_CNT_W-1:0];

    logic     w_cpu_win;
    logic     w_dbg_win;
    logic     w_force;
    logic     w_lock_active;
    rsp_own_t r_rsp_own;

    mem_arb_starve_ctr u_starve_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (dbg_req),
        .gnt       (w_dbg_win),
        .limit     (c_max_wait),
        .force_win (w_force)
    );

`ifdef MEM_ARB_LOCK_EN
    logic r_lock;

    // A locking dbg request claims the memory in its first cycle; the register
    // keeps it claimed while dbg pauses its requests with dbg_lock still high.
    assign w_lock_active = dbg_lock & (r_lock | dbg_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock <= 1'b0;
        end else if (!dbg_lock) begin
            r_lock <= 1'b0;
        end else if (w_dbg_win) begin
            r_lock <= 1'b1;
        end
    end
`else
    assign w_lock_active = 1'b0;
`endif

    // Grants are forced low while reset is asserted, independent of requests.
    always_comb begin
        w_cpu_win = 1'b0;
        w_dbg_win = 1'b0;
        if (rst_n) begin
            if (w_lock_active) begin
                w_dbg_win = dbg_req;
            end else if (w_force) begin
                w_dbg_win = 1'b1;
            end else if (cpu_req) begin
                w_cpu_win = 1'b1;
            end else if (dbg_req) begin
                w_dbg_win = 1'b1;
            end
        end
    end

    always_comb begin
        mem_enbl       = 1'b0;
        mem_write_enbl = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (w_cpu_win) begin
            mem_enbl       = 1'b1;
            mem_write_enbl = cpu_we;
            mem_addr       = cpu_addr;
            mem_write_data = cpu_wdata;
        end else if (w_dbg_win) begin
            mem_enbl       = 1'b1;
            mem_write_enbl = dbg_we;
            mem_addr       = dbg_addr;
            mem_write_data = dbg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_own <= RSP_NONE;
        end else if (w_cpu_win && !cpu_we) begin
            r_rsp_own <= RSP_CPU;
        end else if (w_dbg_win && !dbg_we) begin
            r_rsp_own <= RSP_DBG;
        end else begin
            r_rsp_own <= RSP_NONE;
        end
    end

    assign cpu_gnt    = w_cpu_win;
    assign dbg_gnt    = w_dbg_win;
    assign cpu_stall  = cpu_req & ~w_cpu_win;
    assign cpu_rvalid = (r_rsp_own == RSP_CPU);
    assign dbg_rvalid = (r_rsp_own == RSP_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_data_out : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_data_out : '0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// =============================================================================
// Module  : tb_data_mem_arbiter
// Brief   : Directed self-checking bench for data_mem_arbiter (MAX_WAIT = 4).
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_enbl, mem_write_enbl;
    logic [31:0] mem_addr, mem_write_data, mem_data_out;
`ifdef MEM_ARB_LOCK_EN
    logic        dbg_lock;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    // One-cycle-latency synchronous memory model
    always @(posedge clk) begin
        if (mem_enbl) begin
            if (mem_write_enbl) mem[mem_addr[7:2]] <= mem_write_data;
            else                mem_data_out <= mem[mem_addr[7:2]];
        end
    end

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef MEM_ARB_LOCK_EN
        .dbg_lock       (dbg_lock),
`endif
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_gnt        (cpu_gnt),
        .cpu_stall      (cpu_stall),
        .cpu_rvalid     (cpu_rvalid),
        .cpu_rdata      (cpu_rdata),
        .dbg_req        (dbg_req),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_gnt        (dbg_gnt),
        .dbg_rvalid     (dbg_rvalid),
        .dbg_rdata      (dbg_rdata),
        .mem_enbl       (mem_enbl),
        .mem_write_enbl (mem_write_enbl),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_data_out   (mem_data_out)
    );

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
        dbg_lock = 1'b0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20;
        #2;
        got = {cpu_gnt, dbg_gnt, mem_enbl, mem_write_enbl};
        n_cmp++;
        if (got !== 4'b0000) begin
            n_err++; $display("FAIL reset_grants: got %b want 0000", got);
        end
        step();
        got = {cpu_rvalid, dbg_rvalid, mem_enbl, cpu_gnt};
        n_cmp++;
        if (got !== 4'b0000 || cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin
            n_err++; $display("FAIL reset_outputs: got %b rdata %h/%h want 0000 0/0", got, cpu_rdata, dbg_rdata);
        end
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        got = {cpu_rvalid, dbg_rvalid, mem_enbl, mem_write_enbl};
        n_cmp++;
        if (got !== 4'b0000 || cpu_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            n_err++; $display("FAIL reset_release: got %b rdata %h addr %h want 0000 0 0", got, cpu_rdata, mem_addr);
        end
    endtask

    task automatic test_cpu_read();
        logic [4:0] got;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        #2;
        got = {cpu_gnt, dbg_gnt, mem_enbl, mem_write_enbl, cpu_stall};
        n_cmp++;
        if (got !== 5'b10100 || mem_addr !== 32'h10) begin
            n_err++; $display("FAIL cpu_read_gnt: got %b addr %h want 10100 addr 10", got, mem_addr);
        end
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin
            n_err++; $display("FAIL cpu_read_rsp: got v%b %h dbg v%b %h want v1 deadbeef dbg v0 0",
                              cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata);
        end
        step();
        n_cmp++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0 || mem_enbl !== 1'b0 || mem_addr !== 32'h0) begin
            n_err++; $display("FAIL cpu_read_pulse: got v%b %h en%b addr %h want v0 0 en0 0",
                              cpu_rvalid, cpu_rdata, mem_enbl, mem_addr);
        end
    endtask

    task automatic test_dbg_write_read();
        logic [3:0] got;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h1234;
        #2;
        got = {cpu_gnt, dbg_gnt, mem_enbl, mem_write_enbl};
        n_cmp++;
        if (got !== 4'b0111 || mem_addr !== 32'h20 || mem_write_data !== 32'h1234) begin
            n_err++; $display("FAIL dbg_write_gnt: got %b addr %h wd %h want 0111 20 1234", got, mem_addr, mem_write_data);
        end
        step();
        dbg_we = 1'b0; dbg_wdata = 32'h0;
        #1;
        got = {dbg_rvalid, cpu_rvalid, dbg_gnt, mem_write_enbl};
        n_cmp++;
        if (got !== 4'b0010) begin
            n_err++; $display("FAIL dbg_read_gnt: got %b want 0010", got);
        end
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h1234 || cpu_rvalid !== 1'b0) begin
            n_err++; $display("FAIL dbg_read_rsp: got v%b %h cpu v%b want v1 1234 cpu v0", dbg_rvalid, dbg_rdata, cpu_rvalid);
        end
        step();
    endtask

    task automatic test_contention();
        logic [2:0]  got, exp;
        logic [1:0]  vgot, vexp;
        logic        prev_dbg;
        logic [31:0] exp_data;
        prev_dbg = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'h0;
        dbg_req = 1'b1; dbg_addr = 32'h4;
        for (int c = 1; c <= 8; c++) begin
            #1;
            exp = (c == 5) ? 3'b011 : 3'b100;
            got = {cpu_gnt, dbg_gnt, cpu_stall};
            n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL contention_cyc%0d: got gnt/gnt/stall %b want %b", c, got, exp);
            end
            if (c > 1) begin
                vexp     = prev_dbg ? 2'b01 : 2'b10;
                exp_data = prev_dbg ? 32'h2222_0004 : 32'h1111_0000;
                vgot     = {cpu_rvalid, dbg_rvalid};
                n_cmp++;
                if (vgot !== vexp || (cpu_rdata | dbg_rdata) !== exp_data) begin
                    n_err++; $display("FAIL contention_rsp%0d: got %b %h/%h want %b %h",
                                      c, vgot, cpu_rdata, dbg_rdata, vexp, exp_data);
                end
            end
            prev_dbg = (c == 5);
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] got;
        cpu_req = 1'b1; cpu_addr = 32'h0;
        #1;
        n_cmp++;
        if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
            n_err++; $display("FAIL b2b_g1: got %b want 10", {cpu_gnt, dbg_gnt});
        end
        step();
        cpu_req = 1'b0; dbg_req = 1'b1; dbg_addr = 32'h4;
        #1;
        got = {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid};
        n_cmp++;
        if (got !== 4'b0110 || cpu_rdata !== 32'h1111_0000) begin
            n_err++; $display("FAIL b2b_r1: got %b %h want 0110 11110000", got, cpu_rdata);
        end
        step();
        dbg_req = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h8;
        #1;
        got = {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid};
        n_cmp++;
        if (got !== 4'b1001 || dbg_rdata !== 32'h2222_0004 || cpu_rdata !== 32'h0) begin
            n_err++; $display("FAIL b2b_r2: got %b %h/%h want 1001 0/22220004", got, cpu_rdata, dbg_rdata);
        end
        step();
        idle_inputs();
        #1;
        got = {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid};
        n_cmp++;
        if (got !== 4'b0010 || cpu_rdata !== 32'h3333_0008) begin
            n_err++; $display("FAIL b2b_r3: got %b %h want 0010 33330008", got, cpu_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        logic [5:0] got;
        cpu_req = 1'b1; cpu_addr = 32'h10;
        step();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
            n_err++; $display("FAIL rst_mid_read: got v%b %h want v0 0", cpu_rvalid, cpu_rdata);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            got = {cpu_gnt, dbg_gnt, mem_enbl, mem_write_enbl, cpu_rvalid, dbg_rvalid};
            n_cmp++;
            if (got !== 6'b0 || cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0 || mem_addr !== 32'h0) begin
                n_err++; $display("FAIL rst_mid_after%0d: got %b rdata %h/%h addr %h want all 0",
                                  c, got, cpu_rdata, dbg_rdata, mem_addr);
            end
        end
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        logic [2:0] got;
        cpu_req = 1'b1; cpu_addr = 32'h0;
        dbg_req = 1'b1; dbg_addr = 32'h4; dbg_lock = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            #1;
            got = {cpu_gnt, dbg_gnt, cpu_stall};
            n_cmp++;
            if (got !== 3'b011) begin
                n_err++; $display("FAIL lock_cyc%0d: got %b want 011", c, got);
            end
            step();
        end
        dbg_lock = 1'b0; dbg_req = 1'b0;
        #1;
        got = {cpu_gnt, dbg_gnt, cpu_stall};
        n_cmp++;
        if (got !== 3'b100) begin
            n_err++; $display("FAIL lock_release: got %b want 100", got);
        end
        step();
        idle_inputs();
        step();
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h1111_0000;
        mem[1] = 32'h2222_0004;
        mem[2] = 32'h3333_0008;
        mem[4] = 32'hDEADBEEF;
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_cpu_read();
        test_dbg_write_read();
        test_contention();
        test_back_to_back();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter placed between the processor datapath and the single-port data memory, sharing that memory between the CPU load/store path and a debug/loader master. CPU accesses have priority; a starvation counter guarantees the debug master a slot. The arbiter tracks which requester owns each outstanding read and returns the data to it one cycle later. It also raises a stall that freezes the program counter while the CPU is waiting.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports
- MAX_WAIT, 4, consecutive denied dbg cycles before dbg is forced to win; range 1..15
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- cpu_req / cpu_we  in  1  CPU access request / write (1) or read (0)
- cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address / write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; holds PC and pipeline
- cpu_rvalid / cpu_rdata  out  1 / DATA_W  CPU read response
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as cpu_*, debug master
- dbg_lock  in  1  hold memory for dbg (only with MEM_ARB_LOCK_EN)
- mem_enbl / mem_write_enbl  out  1  memory enable / write enable
- mem_addr / mem_write_data  out  ADDR_W / DATA_W  memory address / data
- mem_data_out  in  DATA_W  memory read data; valid 1 cycle after a read issue

## Operation
- Each cycle at most one requester is granted. The grant is combinational from the current req and registered state.
- Winner rules, in order:
  1. Lock active: dbg wins; CPU gets nothing.
  2. dbg_req and wait_cnt == MAX_WAIT: dbg wins.
  3. cpu_req: CPU wins.
  4. dbg_req: dbg wins.
  5. Otherwise: idle.
- The winner's addr/wdata/we drive mem_*. mem_enbl = any grant. mem_write_enbl = grant & winner's we.
- When idle, mem_enbl = 0, mem_write_enbl = 0 and mem_addr/mem_write_data = 0.
- wait_cnt (4 bit):
  - +1 per cycle with dbg_req=1 and dbg_gnt=0, saturating at MAX_WAIT.
  - Cleared on dbg_gnt or dbg_req=0.
- Response owner register rsp_own ∈ {RSP_NONE, RSP_CPU, RSP_DBG}:
  - Loads the read winner's tag on a granted read.
  - Loads RSP_NONE on a write or idle.
- x_rvalid = (rsp_own == x). x_rdata = mem_data_out when x_rvalid, else 0.
- Back-to-back reads by different owners are legal. Each response follows its own grant by exactly one cycle.
- Writes produce no response. They complete at the grant edge.

## Timing
- Grant latency: 0 cycles when the requester wins. Requester holds req/addr/we/wdata stable until gnt.
- Read data latency: rvalid exactly 1 cycle after gnt, single-cycle pulse.
- Worst-case dbg wait under continuous cpu_req: MAX_WAIT cycles; dbg is granted on cycle MAX_WAIT+1.
- After a forced dbg grant, CPU has priority again the next cycle.
- Reset values (asserted, and the first cycle after release): rsp_own = RSP_NONE, wait_cnt = 0, lock = 0, all rvalid = 0, all rdata = 0.
- During reset all gnt, mem_enbl and mem_write_enbl are 0 regardless of req.
- Reset during an outstanding read discards the response; no rvalid after release.
- cpu_req and dbg_req both rising in the same cycle with wait_cnt = 0: CPU wins and wait_cnt becomes 1.

## Configuration
- MEM_ARB_LOCK_EN defined:
  - dbg_lock port exists.
  - Lock register sets on a dbg grant with dbg_lock=1 and clears on the first cycle dbg_lock=0.
  - While set, cpu_gnt=0, so cpu_stall follows cpu_req. wait_cnt stays 0.
- Not defined: no dbg_lock port, no lock register; arbitration uses rules 2–5 only.

## Structure
- Package mem_arb_pkg:
  - rsp_own_t enum (RSP_NONE, RSP_CPU, RSP_DBG)
  - WAIT_CNT_W = 4
  - default MAX_WAIT constant
- One sub-module, mem_arb_starve_ctr: saturating wait counter with inputs req, gnt and limit, and output force.
- Grant mux, rsp_own register and lock register live in data_mem_arbiter.

## Test plan
- CPU only: read addr 0x10 (memory holds 0xDEADBEEF) → cpu_gnt same cycle, cpu_rvalid=1 with 0xDEADBEEF next cycle, dbg_rvalid=0.
- dbg only: write 0x1234 to 0x20, then read 0x20 → mem_write_enbl pulse on the write; dbg_rdata=0x1234 one cycle after the read grant.
- Contention, MAX_WAIT=4, both req held 8 cycles → CPU granted cycles 1–4, dbg cycle 5, CPU cycles 6–8; cpu_stall=1 only on cycle 5.
- Alternating reads CPU@0x0, dbg@0x4, CPU@0x8 back-to-back → each rvalid lands on the correct port one cycle after its own grant.
- Reset asserted the cycle after a granted CPU read → no cpu_rvalid; all outputs 0 until a new request arrives.
- MEM_ARB_LOCK_EN: dbg_lock=1 for 6 cycles with cpu_req=1 → cpu_stall=1 for all 6 cycles; CPU granted the cycle after dbg_lock drops.
